cu_pipe: RTL



---
 rtl/cu_pipe_pkg.sv | 110 +++++++++++
 rtl/cu_decode.sv | 131 +++++++++++++
 rtl/cu_pipe.sv | 101 ++++++++++
 3 files changed

// File: rtl/cu_pipe_pkg.sv
// Shared ISA and control-unit encodings used by the decode stage and its consumers.
// Opcode/funct constants follow RV32I/M/Zicsr; control-field encodings match the existing CU.
package cu_pipe_pkg;

    localparam logic [6:0] RVOP_LUI     = 7'b0110111;
    localparam logic [6:0] RVOP_AUIPC   = 7'b0010111;
    localparam logic [6:0] RVOP_JAL     = 7'b1101111;
    localparam logic [6:0] RVOP_JALR    = 7'b1100111;
    localparam logic [6:0] RVOP_BRANCH  = 7'b1100011;
    localparam logic [6:0] RVOP_LOAD    = 7'b0000011;
    localparam logic [6:0] RVOP_STORE   = 7'b0100011;
    localparam logic [6:0] RVOP_OPIMM   = 7'b0010011;
    localparam logic [6:0] RVOP_OP      = 7'b0110011;
    localparam logic [6:0] RVOP_MISCMEM = 7'b0001111;
    localparam logic [6:0] RVOP_SYSTEM  = 7'b1110011;

    localparam logic [2:0] RVF3_ADDSUB = 3'd0;
    localparam logic [2:0] RVF3_SLL    = 3'd1;
    localparam logic [2:0] RVF3_SLT    = 3'd2;
    localparam logic [2:0] RVF3_SLTU   = 3'd3;
    localparam logic [2:0] RVF3_XOR    = 3'd4;
    localparam logic [2:0] RVF3_SR     = 3'd5;
    localparam logic [2:0] RVF3_OR     = 3'd6;
    localparam logic [2:0] RVF3_AND    = 3'd7;
    localparam logic [2:0] RVF3_PRIV   = 3'd0;

    localparam logic [6:0] RVF7_BASE   = 7'b0000000;
    localparam logic [6:0] RVF7_ALT    = 7'b0100000;
    localparam logic [6:0] RVF7_MULDIV = 7'b0000001;

    localparam logic [3:0] ALUOP_ADD  = 4'd0;
    localparam logic [3:0] ALUOP_SUB  = 4'd1;
    localparam logic [3:0] ALUOP_SLL  = 4'd2;
    localparam logic [3:0] ALUOP_SLT  = 4'd3;
    localparam logic [3:0] ALUOP_SLTU = 4'd4;
    localparam logic [3:0] ALUOP_XOR  = 4'd5;
    localparam logic [3:0] ALUOP_SRL  = 4'd6;
    localparam logic [3:0] ALUOP_SRA  = 4'd7;
    localparam logic [3:0] ALUOP_OR   = 4'd8;
    localparam logic [3:0] ALUOP_AND  = 4'd9;

    localparam logic [1:0] RDSRC_ALU = 2'd0;
    localparam logic [1:0] RDSRC_MEM = 2'd1;
    localparam logic [1:0] RDSRC_PC4 = 2'd2;
    localparam logic [1:0] RDSRC_CSR = 2'd3;

    // alu_src1 selects the operand pairing; alu_src2 picks immediate over rs2
    localparam logic [1:0] ALUSRC1_RS1  = 2'd0;
    localparam logic [1:0] ALUSRC1_IMMI = 2'd1;
    localparam logic [1:0] ALUSRC1_PC   = 2'd2;
    localparam logic [1:0] ALUSRC1_ZERO = 2'd3;
    localparam logic       ALUSRC2_RS2  = 1'b0;
    localparam logic       ALUSRC2_IMM  = 1'b1;

    localparam logic [2:0] BRANCH_EQ  = 3'd0;
    localparam logic [2:0] BRANCH_NE  = 3'd1;
    localparam logic [2:0] BRANCH_LT  = 3'd4;
    localparam logic [2:0] BRANCH_GE  = 3'd5;
    localparam logic [2:0] BRANCH_LTU = 3'd6;
    localparam logic [2:0] BRANCH_GEU = 3'd7;

    // CSR op codes coincide with the Zicsr funct3 values
    localparam logic [2:0] CSR_NOP = 3'd0;
    localparam logic [2:0] CSR_RW  = 3'd1;
    localparam logic [2:0] CSR_RS  = 3'd2;
    localparam logic [2:0] CSR_RC  = 3'd3;
    localparam logic [2:0] CSR_RWI = 3'd5;
    localparam logic [2:0] CSR_RSI = 3'd6;
    localparam logic [2:0] CSR_RCI = 3'd7;

    typedef struct packed {
        logic       pc_write;
        logic       rd_write;
        logic       mem_write;
        logic       fast_jump;
        logic       branch;
        logic       alu_src2;
        logic       csr_wr_en;
        logic [1:0] rd_write_src;
        logic [1:0] alu_src1;
        logic [3:0] alu_op;
        logic [2:0] branch_condition;
        logic [2:0] csr_op;
        logic       muldiv_en;
        logic [2:0] muldiv_op;
        logic       illegal;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '{
        pc_write: 1'b0, rd_write: 1'b0, mem_write: 1'b0, fast_jump: 1'b0,
        branch: 1'b0, alu_src2: ALUSRC2_RS2, csr_wr_en: 1'b0,
        rd_write_src: RDSRC_ALU, alu_src1: ALUSRC1_RS1, alu_op: ALUOP_ADD,
        branch_condition: BRANCH_EQ, csr_op: CSR_NOP, muldiv_en: 1'b0,
        muldiv_op: 3'd0, illegal: 1'b0
    };

    function automatic logic [3:0] alu_op_of(input logic [2:0] f3, input logic alt);
        case (f3)
            RVF3_ADDSUB: alu_op_of = alt ? ALUOP_SUB : ALUOP_ADD;
            RVF3_SLL:    alu_op_of = ALUOP_SLL;
            RVF3_SLT:    alu_op_of = ALUOP_SLT;
            RVF3_SLTU:   alu_op_of = ALUOP_SLTU;
            RVF3_XOR:    alu_op_of = ALUOP_XOR;
            RVF3_SR:     alu_op_of = alt ? ALUOP_SRA : ALUOP_SRL;
            RVF3_OR:     alu_op_of = ALUOP_OR;
            default:     alu_op_of = ALUOP_AND;
        endcase
    endfunction

endpackage

// File: rtl/cu_decode.sv
// Combinational RV32I(+M, +Zicsr) decode: instruction word to control bundle.
// Anything not recognised, or switched off by a parameter, yields an all-zero bundle with illegal set.
module cu_decode
    import cu_pipe_pkg::*;
#(
    parameter int M_EXT   = 0,
    parameter int CSR_EXT = 1
) (
    input  logic [31:0] instr,
    output ctrl_t       ctrl
);

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic       unused_rs2;
    ctrl_t      c;
    logic       legal;

    assign opcode     = instr[6:0];
    assign rd         = instr[11:7];
    assign f3         = instr[14:12];
    assign rs1        = instr[19:15];
    assign f7         = instr[31:25];
    assign unused_rs2 = ^instr[24:20];

    always_comb begin
        c     = CTRL_IDLE;
        legal = 1'b0;
        case (opcode)
            RVOP_LUI: begin
                legal = 1'b1;
                c.rd_write = 1'b1;
                c.alu_src1 = ALUSRC1_ZERO;
                c.alu_src2 = ALUSRC2_IMM;
            end
            RVOP_AUIPC: begin
                legal = 1'b1;
                c.rd_write = 1'b1;
                c.alu_src1 = ALUSRC1_PC;
                c.alu_src2 = ALUSRC2_IMM;
            end
            RVOP_JAL: begin
                legal = 1'b1;
                c.pc_write     = 1'b1;
                c.fast_jump    = 1'b1;
                c.rd_write     = 1'b1;
                c.rd_write_src = RDSRC_PC4;
                c.alu_src1     = ALUSRC1_PC;
                c.alu_src2     = ALUSRC2_IMM;
            end
            RVOP_JALR: begin
                legal = (f3 == 3'd0);
                c.pc_write     = 1'b1;
                c.rd_write     = 1'b1;
                c.rd_write_src = RDSRC_PC4;
                c.alu_src1     = ALUSRC1_IMMI;
                c.alu_src2     = ALUSRC2_IMM;
            end
            RVOP_BRANCH: begin
                legal = (f3 != 3'd2) && (f3 != 3'd3);
                c.branch           = 1'b1;
                c.branch_condition = f3;
                c.alu_op           = ALUOP_SUB;
            end
            RVOP_LOAD: begin
                legal = (f3 != 3'd3) && (f3 != 3'd6) && (f3 != 3'd7);
                c.rd_write     = 1'b1;
                c.rd_write_src = RDSRC_MEM;
                c.alu_src1     = ALUSRC1_IMMI;
                c.alu_src2     = ALUSRC2_IMM;
            end
            RVOP_STORE: begin
                legal = (f3 <= 3'd2);
                c.mem_write = 1'b1;
                c.alu_src1  = ALUSRC1_IMMI;
                c.alu_src2  = ALUSRC2_IMM;
            end
            RVOP_OPIMM: begin
                if (f3 == RVF3_SLL)
                    legal = (f7 == RVF7_BASE);
                else if (f3 == RVF3_SR)
                    legal = (f7 == RVF7_BASE) || (f7 == RVF7_ALT);
                else
                    legal = 1'b1;
                c.rd_write = 1'b1;
                c.alu_src1 = ALUSRC1_IMMI;
                c.alu_src2 = ALUSRC2_IMM;
                c.alu_op   = alu_op_of(f3, (f3 == RVF3_SR) && instr[30]);
            end
            RVOP_OP: begin
                c.rd_write = 1'b1;
                if (f7 == RVF7_BASE) begin
                    legal    = 1'b1;
                    c.alu_op = alu_op_of(f3, 1'b0);
                end else if (f7 == RVF7_ALT) begin
                    legal    = (f3 == RVF3_ADDSUB) || (f3 == RVF3_SR);
                    c.alu_op = alu_op_of(f3, 1'b1);
                end else if (f7 == RVF7_MULDIV) begin
                    legal       = (M_EXT != 0);
                    c.muldiv_en = 1'b1;
                    c.muldiv_op = f3;
                end
            end
            RVOP_MISCMEM: begin
                legal = (f3 == 3'd0) || (f3 == 3'd1);
            end
            RVOP_SYSTEM: begin
                // ECALL/EBREAK/xRET are left to the trap path and surface as illegal here
                legal = (CSR_EXT != 0) && (f3 != RVF3_PRIV) && (f3 != 3'd4);
                c.rd_write     = 1'b1;
                c.rd_write_src = RDSRC_CSR;
                c.csr_op       = f3;
                c.csr_wr_en    = !f3[1] || (rs1 != 5'd0);
            end
            default: legal = 1'b0;
        endcase

        if (!legal) begin
            c         = CTRL_IDLE;
            c.illegal = 1'b1;
        end else if (rd == 5'd0) begin
            c.rd_write = 1'b0;
        end
    end

    assign ctrl = c;

endmodule

// File: rtl/cu_pipe.sv
// Decode stage: registers the cu_decode bundle behind a valid/ready handshake
// and stalls acceptance while a multi-cycle muldiv op is outstanding.
module cu_pipe
    import cu_pipe_pkg::*;
#(
    parameter int M_EXT      = 0,
    parameter int CSR_EXT    = 1,
    parameter int MULDIV_LAT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [31:0] in_pc,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic        pc_write,
    output logic        rd_write,
    output logic        mem_write,
    output logic        fast_jump,
    output logic        branch,
    output logic        alu_src2,
    output logic        csr_wr_en,
    output logic [1:0]  rd_write_src,
    output logic [1:0]  alu_src1,
    output logic [3:0]  alu_op,
    output logic [2:0]  branch_condition,
    output logic [2:0]  csr_op,
    output logic        muldiv_en,
    output logic [2:0]  muldiv_op,
    output logic        illegal,
    output logic        busy
);

    ctrl_t       dec;
    ctrl_t       ctrl_p1;
    logic        vld_p1;
    logic [31:0] pc_p1;
    logic [3:0]  busy_cnt;
    logic        accept;

    cu_decode #(
        .M_EXT  (M_EXT),
        .CSR_EXT(CSR_EXT)
    ) u_decode (
        .instr(instr),
        .ctrl (dec)
    );

    assign busy     = (busy_cnt != 4'd0);
    assign in_ready = !busy && (!vld_p1 || out_ready);
    assign accept   = in_valid && in_ready && !flush;

    // Stage p1: output register and muldiv block counter
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1   <= 1'b0;
            busy_cnt <= 4'd0;
            ctrl_p1  <= CTRL_IDLE;
            pc_p1    <= 32'd0;
        end else if (flush) begin
            vld_p1   <= 1'b0;
            busy_cnt <= 4'd0;
        end else begin
            if (accept) begin
                vld_p1  <= 1'b1;
                ctrl_p1 <= dec;
                pc_p1   <= in_pc;
            end else if (out_ready) begin
                vld_p1 <= 1'b0;
            end

            if (accept && dec.muldiv_en)
                busy_cnt <= 4'(MULDIV_LAT);
            else if (busy_cnt != 4'd0)
                busy_cnt <= busy_cnt - 4'd1;
        end
    end

    assign out_valid        = vld_p1;
    assign out_pc           = pc_p1;
    assign pc_write         = ctrl_p1.pc_write;
    assign rd_write         = ctrl_p1.rd_write;
    assign mem_write        = ctrl_p1.mem_write;
    assign fast_jump        = ctrl_p1.fast_jump;
    assign branch           = ctrl_p1.branch;
    assign alu_src2         = ctrl_p1.alu_src2;
    assign csr_wr_en        = ctrl_p1.csr_wr_en;
    assign rd_write_src     = ctrl_p1.rd_write_src;
    assign alu_src1         = ctrl_p1.alu_src1;
    assign alu_op           = ctrl_p1.alu_op;
    assign branch_condition = ctrl_p1.branch_condition;
    assign csr_op           = ctrl_p1.csr_op;
    assign muldiv_en        = ctrl_p1.muldiv_en;
    assign muldiv_op        = ctrl_p1.muldiv_op;
    assign illegal          = ctrl_p1.illegal;

endmodule
